// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display.
// Walks a 16-phase scan count (4 phases per digit, anode on in phase 01),
// decodes the addressed nibble to active-low segments, and stages new
// display values so that they are committed only at a frame boundary.
//
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   enable         - 1 = scanning, 0 = dark with counters held at 0
//   data_in, load  - value to stage and its request strobe
//   load_ready     - staging register free (registered state decode)
//   load_ack       - one-cycle pulse after a staged value is committed
//   scan_count     - phase counter for the anode selector
//   digit_val      - nibble of the digit addressed by scan_count[3:2]
//   seg            - active-low segments {g,f,e,d,c,b,a}
module seg7_scan_ctrl #(
    parameter int unsigned PRESCALE   = 50000,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] data_in,
    input  logic        load,
    output logic        load_ready,
    output logic        load_ack,
    output logic [3:0]  scan_count,
    output logic [3:0]  digit_val,
    output logic [6:0]  seg
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
    localparam logic [PRESCALE_W-1:0] PRE_LAST  = PRESCALE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]      CNT_LAST  = 4'hF;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    state_e                  state_q,      state_d;
    logic [PRESCALE_W-1:0]   presc_q,      presc_d;
    logic [CNT_W-1:0]        scan_q,       scan_d;
    logic [DATA_W-1:0]       staging_q,    staging_d;
    logic [DATA_W-1:0]       display_q,    display_d;
    logic                    load_ready_q, load_ready_d;
    logic                    load_ack_q,   load_ack_d;

    logic                    tick_c;
    logic                    frame_c;
    logic [NIB_W-1:0]        nibble_c;
    logic [SEG_W-1:0]        seg_c;

    // Prescaler and scan counter; both forced to 0 while disabled.
    always_comb begin
        tick_c  = enable && (presc_q == PRE_LAST);
        frame_c = tick_c && (scan_q == CNT_LAST);
        presc_d = presc_q;
        scan_d  = scan_q;
        if (!enable) begin
            presc_d = '0;
            scan_d  = '0;
        end else if (tick_c) begin
            presc_d = '0;
            scan_d  = scan_q + CNT_W'(1);
        end else begin
            presc_d = presc_q + PRESCALE_W'(1);
        end
    end

    // Load FSM: stage in IDLE, commit at the frame boundary in PENDING.
    always_comb begin
        state_d    = state_q;
        staging_d  = staging_q;
        display_d  = display_q;
        load_ack_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    staging_d = data_in;
                    state_d   = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (frame_c) begin
                    display_d  = staging_q;
                    load_ack_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        load_ready_d = (state_d == ST_IDLE);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            scan_q       <= '0;
            staging_q    <= '0;
            display_q    <= '0;
            load_ready_q <= 1'b1;
            load_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            scan_q       <= scan_d;
            staging_q    <= staging_d;
            display_q    <= display_d;
            load_ready_q <= load_ready_d;
            load_ack_q   <= load_ack_d;
        end
    end

    // Digit 0 is the most significant nibble.
    always_comb begin
        nibble_c = '0;
        unique case (scan_q[3:2])
            2'd0:    nibble_c = display_q[15:12];
            2'd1:    nibble_c = display_q[11:8];
            2'd2:    nibble_c = display_q[7:4];
            2'd3:    nibble_c = display_q[3:0];
            default: nibble_c = '0;
        endcase
    end

    // Hex to active-low segments; lit only in the anode-on phase.
    always_comb begin
        seg_c = SEG_BLANK;
        if (enable && (scan_q[1:0] == 2'b01)) begin
            unique case (nibble_c)
                4'h0: seg_c = 7'h40;
                4'h1: seg_c = 7'h79;
                4'h2: seg_c = 7'h24;
                4'h3: seg_c = 7'h30;
                4'h4: seg_c = 7'h19;
                4'h5: seg_c = 7'h12;
                4'h6: seg_c = 7'h02;
                4'h7: seg_c = 7'h78;
                4'h8: seg_c = 7'h00;
                4'h9: seg_c = 7'h10;
                4'hA: seg_c = 7'h08;
                4'hB: seg_c = 7'h03;
                4'hC: seg_c = 7'h46;
                4'hD: seg_c = 7'h21;
                4'hE: seg_c = 7'h06;
                4'hF: seg_c = 7'h0E;
                default: seg_c = SEG_BLANK;
            endcase
        end
    end

    assign load_ready = load_ready_q;
    assign load_ack   = load_ack_q;
    assign scan_count = scan_q;
    assign digit_val  = nibble_c;
    assign seg        = seg_c;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with PRESCALE=4 (one frame = 64 clocks).
// Each cycle, the bench's frame-arithmetic model pushes the expected outputs
// to a queue; they are popped and compared on the following falling edge.
module tb_seg7_scan_ctrl;

    localparam int unsigned PRE   = 4;
    localparam int unsigned FRAME = 16 * PRE;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] data_in;
    logic        load;
    logic        load_ready;
    logic        load_ack;
    logic [3:0]  scan_count;
    logic [3:0]  digit_val;
    logic [6:0]  seg;

    seg7_scan_ctrl #(.PRESCALE(PRE), .PRESCALE_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .data_in    (data_in),
        .load       (load),
        .load_ready (load_ready),
        .load_ack   (load_ack),
        .scan_count (scan_count),
        .digit_val  (digit_val),
        .seg        (seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cnt;
        logic [6:0] seg;
        logic [3:0] dv;
        logic       rdy;
        logic       ack;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_ack = 0;

    // Model: cycles since scanning (re)started, staged value, shown value.
    int          n = 0;
    bit          pend = 1'b0;
    logic [15:0] pend_val = '0;
    logic [15:0] disp = '0;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                 7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[v];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    // Advance one clock: predict, push, clock, pop, compare.
    task automatic cyc();
        exp_t       e;
        exp_t       got;
        bit         pend_old;
        logic       ack_e;
        logic [3:0] cnt;
        ack_e = 1'b0;
        if (reset) begin
            n    = 0;
            pend = 1'b0;
            disp = '0;
        end else begin
            pend_old = pend;
            if (enable) begin
                n++;
                if ((n % FRAME == 0) && pend_old) begin
                    disp  = pend_val;
                    pend  = 1'b0;
                    ack_e = 1'b1;
                end
            end else begin
                n = 0;
            end
            if (load && !pend_old) begin
                pend     = 1'b1;
                pend_val = data_in;
            end
        end
        cnt   = 4'((n / PRE) % 16);
        e.cnt = cnt;
        e.dv  = 4'(disp >> (4 * (3 - int'(cnt[3:2]))));
        e.seg = (enable && cnt[1:0] == 2'b01) ? hex7(e.dv) : 7'h7F;
        e.rdy = !pend;
        e.ack = ack_e;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got = sb.pop_front();
        if (load_ack === 1'b1) n_ack++;
        chk("scan_count", 16'(scan_count), 16'(got.cnt));
        chk("seg",        16'(seg),        16'(got.seg));
        chk("digit_val",  16'(digit_val),  16'(got.dv));
        chk("load_ready", 16'(load_ready), 16'(got.rdy));
        chk("load_ack",   16'(load_ack),   16'(got.ack));
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cyc();
    endtask

    task automatic do_load(input logic [15:0] v);
        data_in = v;
        load    = 1'b1;
        cyc();
        load    = 1'b0;
    endtask

    int ack_before;

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        load    = 1'b0;
        data_in = '0;
        @(negedge clk);
        run(2);
        reset = 1'b0;

        // Full frame and wrap with display = 0.
        run(FRAME + 4);

        // Load, ignored second load while pending, commit, then a full frame.
        do_load(16'h12AF);
        run(10);
        do_load(16'h8888);
        run(2 * FRAME);

        // Load exactly on a frame boundary from IDLE.
        while (n % FRAME != FRAME - 1) cyc();
        do_load(16'h5C3E);
        run(FRAME + 8);

        // Disable mid-frame, load while dark, re-enable.
        run(22);
        enable = 1'b0;
        run(3);
        do_load(16'h0D96);
        run(6);
        enable = 1'b1;
        run(FRAME + 10);

        // Reset while pending: staged value discarded, no ack.
        do_load(16'hBEEF);
        run(5);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        ack_before = n_ack;
        run(FRAME + 10);
        chk("no_ack_after_reset", 16'(n_ack - ack_before), 16'd0);
        chk("total_acks", 16'(n_ack), 16'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
